// File: rtl/tt_bist_pkg.sv
// Shared types and constants for the tt_bist loopback self-test block.
package tt_bist_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int unsigned ERR_W  = 8;
   localparam int unsigned VCNT_W = 16;

   // Right-shifting Galois toggle masks of maximal-length polynomials, indexed by WIDTH.
   localparam logic [15:0] LFSR_TAPS [4:16] = '{
      16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
      16'h0500, 16'h0E08, 16'h1C80, 16'h3802, 16'h6000, 16'hD008
   };

endpackage

// File: rtl/tt_bist_lfsr.sv
// Maximal-length Galois LFSR: reloads SEED on load, advances once per cycle while step is high.
module tt_bist_lfsr
   import tt_bist_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   output logic [WIDTH-1:0] state
);

   localparam logic [15:0]      TAPS_FULL = LFSR_TAPS[WIDTH];
   localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

   logic [WIDTH-1:0] state_nxt;

   always_comb begin
      state_nxt = state >> 1;
      if (state[0]) state_nxt = state_nxt ^ TAPS;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    state <= SEED;
      else if (load) state <= SEED;
      else if (step) state <= state_nxt;
   end

endmodule

// File: rtl/tt_bist_loopback.sv
// Pattern-generate / loopback-compare BIST controller.
// TT_BIST_ERRCNT_EN selects a saturating 8-bit mismatch counter instead of a sticky flag.
module tt_bist_loopback
   import tt_bist_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter int unsigned      N_VEC = 255,
   parameter int unsigned      LAT   = 1,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   output logic [WIDTH-1:0] pattern_out,
   output logic [WIDTH-1:0] pattern_oe,
   input  logic [WIDTH-1:0] capture_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [VCNT_W-1:0] LAST_VEC = VCNT_W'(N_VEC - 1);
   localparam logic [VCNT_W-1:0] LAST_DRN = (LAT == 0) ? '0 : VCNT_W'(LAT - 1);

   state_t             state;
   state_t             state_nxt;
   logic [VCNT_W-1:0]  vcnt;
   logic [WIDTH-1:0]   lfsr_q;
   logic               start_run;
   logic               cur_vld;
   logic               exp_vld;
   logic [WIDTH-1:0]   exp_data;
   logic               mismatch;
   logic [ERR_W-1:0]   err;

   assign start_run = ena && start && (state == IDLE || state == DONE);
   assign cur_vld   = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      done        = 1'b0;
      pass        = 1'b0;
      pattern_out = '0;
      pattern_oe  = '0;
      case (state)
         IDLE: if (start_run) state_nxt = RUN;
         RUN: begin
            busy        = 1'b1;
            pattern_out = lfsr_q;
            pattern_oe  = '1;
            if (vcnt == LAST_VEC) state_nxt = (LAT == 0) ? DONE : DRAIN;
         end
         DRAIN: begin
            busy       = 1'b1;
            pattern_oe = '1;
            if (vcnt == LAST_DRN) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            pass = (err == '0);
            if (start_run) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
      if (!ena) state_nxt = IDLE;
   end

   // One counter times both RUN and DRAIN; it restarts on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            vcnt <= '0;
      else if (state_nxt != state)           vcnt <= '0;
      else if (state == RUN || state == DRAIN) vcnt <= vcnt + VCNT_W'(1);
   end

   tt_bist_lfsr #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (start_run),
      .step  (cur_vld && ena),
      .state (lfsr_q)
   );

   generate
      if (LAT == 0) begin : g_nodly
         assign exp_vld  = cur_vld;
         assign exp_data = pattern_out;
      end else begin : g_dly
         logic             vld_sr [LAT];
         logic [WIDTH-1:0] dat_sr [LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < LAT; i++) begin
                  vld_sr[i] <= 1'b0;
                  dat_sr[i] <= '0;
               end
            end else if (!ena || start_run) begin
               for (int unsigned i = 0; i < LAT; i++) begin
                  vld_sr[i] <= 1'b0;
                  dat_sr[i] <= '0;
               end
            end else begin
               vld_sr[0] <= cur_vld;
               dat_sr[0] <= pattern_out;
               for (int unsigned i = 1; i < LAT; i++) begin
                  vld_sr[i] <= vld_sr[i-1];
                  dat_sr[i] <= dat_sr[i-1];
               end
            end
         end

         assign exp_vld  = vld_sr[LAT-1];
         assign exp_data = dat_sr[LAT-1];
      end
   endgenerate

   assign mismatch = ena && exp_vld && (capture_in != exp_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         err <= '0;
      else if (start_run) err <= '0;
      else if (mismatch) begin
`ifdef TT_BIST_ERRCNT_EN
         if (err != '1) err <= err + ERR_W'(1);
`else
         err <= ERR_W'(1);
`endif
      end
   end

   assign err_count = err;

endmodule

// File: tb/tb_tt_bist_loopback.sv
// Randomized loopback bench: three configurations checked against a run-level reference model.
module tb_tt_bist_loopback;

   localparam int unsigned NV [3] = '{255, 400, 1};
   localparam int unsigned LT [3] = '{1, 2, 0};
   localparam int unsigned WD [3] = '{8, 16, 8};
   localparam int unsigned SD [3] = '{1, 16'hACE1, 8'h5A};
   localparam int unsigned NONE   = 32'hFFFF_FFFF;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  ena_v   = '0;
   logic [2:0]  start_v = '0;
   logic [15:0] corr [3];

   logic [7:0]  a_pat, a_oe, a_cap, a_err;
   logic [7:0]  a_pipe = '0;
   logic        a_busy, a_done, a_pass;
   logic [15:0] b_pat, b_oe, b_cap;
   logic [15:0] b_p0 = '0, b_p1 = '0;
   logic [7:0]  b_err;
   logic        b_busy, b_done, b_pass;
   logic [7:0]  c_pat, c_oe, c_cap, c_err;
   logic        c_busy, c_done, c_pass;

   int unsigned sel = 0;
   logic [15:0] s_pat, s_oe;
   logic [7:0]  s_err;
   logic        s_busy, s_done, s_pass;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [15:0] vq [$];
   logic [15:0] ref_q [$];

   always #5 clk = ~clk;

   tt_bist_loopback #(.WIDTH(8), .N_VEC(NV[0]), .LAT(LT[0]), .SEED(8'(SD[0]))) u_a (
      .clk(clk), .rst_n(rst_n), .ena(ena_v[0]), .start(start_v[0]),
      .pattern_out(a_pat), .pattern_oe(a_oe), .capture_in(a_cap),
      .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err));

   tt_bist_loopback #(.WIDTH(16), .N_VEC(NV[1]), .LAT(LT[1]), .SEED(16'(SD[1]))) u_b (
      .clk(clk), .rst_n(rst_n), .ena(ena_v[1]), .start(start_v[1]),
      .pattern_out(b_pat), .pattern_oe(b_oe), .capture_in(b_cap),
      .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err));

   tt_bist_loopback #(.WIDTH(8), .N_VEC(NV[2]), .LAT(LT[2]), .SEED(8'(SD[2]))) u_c (
      .clk(clk), .rst_n(rst_n), .ena(ena_v[2]), .start(start_v[2]),
      .pattern_out(c_pat), .pattern_oe(c_oe), .capture_in(c_cap),
      .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err));

   // External loopback channels: LAT register stages, each vector optionally corrupted.
   always @(posedge clk) begin
      a_pipe <= a_pat ^ corr[0][7:0];
      b_p0   <= b_pat ^ corr[1];
      b_p1   <= b_p0;
   end
   assign a_cap = a_pipe;
   assign b_cap = b_p1;
   assign c_cap = c_pat ^ corr[2][7:0];

   always_comb begin
      case (sel)
         1: begin
            s_pat = b_pat; s_oe = b_oe; s_err = b_err;
            s_busy = b_busy; s_done = b_done; s_pass = b_pass;
         end
         2: begin
            s_pat = {8'h00, c_pat}; s_oe = {8'h00, c_oe}; s_err = c_err;
            s_busy = c_busy; s_done = c_done; s_pass = c_pass;
         end
         default: begin
            s_pat = {8'h00, a_pat}; s_oe = {8'h00, a_oe}; s_err = a_err;
            s_busy = a_busy; s_done = a_done; s_pass = a_pass;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_err(input int unsigned m);
`ifdef TT_BIST_ERRCNT_EN
      return (m > 255) ? 8'd255 : 8'(m);
`else
      return (m != 0) ? 8'd1 : 8'd0;
`endif
   endfunction

   // mode: 0 ideal, 1 bit0 stuck low, 2 inverted, 3 random corruption.
   // kind: 0 full run, 1 drop ena at cycle 'at', 2 assert rst_n at cycle 'at'.
   task automatic run(input int unsigned id, input int unsigned mode, input int unsigned kind,
                      input int unsigned at, input int unsigned poke, input string tag);
      int unsigned n, lat, mism, cyc, bad_busy, bad_pat, bad_vec;
      logic [15:0] mask, c;
      bit seen [logic [15:0]];
      n = NV[id]; lat = LT[id];
      mism = 0; bad_busy = 0; bad_pat = 0; bad_vec = 0;
      mask = 16'((32'd1 << WD[id]) - 32'd1);
      sel = id;
      vq.delete();
      @(negedge clk);
      ena_v[id] = 1'b1;
      start_v[id] = 1'b1;
      @(negedge clk);
      start_v[id] = 1'b0;
      for (cyc = 0; cyc < n + lat + 20; cyc++) begin
         if (s_done) break;
         c = '0;
         if (cyc < n) begin
            vq.push_back(s_pat);
            case (mode)
               1: c = s_pat & 16'h0001;
               2: c = mask;
               3: if ($urandom_range(0, 3) == 0) c = 16'($urandom) & mask;
               default: c = '0;
            endcase
            if (c != '0) mism++;
         end else if (s_pat != '0) begin
            bad_pat++;
         end
         corr[id] = c;
         if (s_busy !== 1'b1 || s_oe !== mask) bad_busy++;
         start_v[id] = (cyc == poke);
         if (kind != 0 && cyc == at) begin
            corr[id] = '0;
            start_v[id] = 1'b0;
            if (kind == 1) begin
               ena_v[id] = 1'b0;
               @(negedge clk);
            end else begin
               #2 rst_n = 1'b0;
               #1;
            end
            check({tag, "_ab_busy"}, s_busy, 0);
            check({tag, "_ab_oe"},   s_oe,   0);
            check({tag, "_ab_pat"},  s_pat,  0);
            check({tag, "_ab_done"}, {s_done, s_pass}, 0);
            check({tag, "_ab_err"},  s_err,  0);
            check({tag, "_ab_prof"}, bad_busy + bad_pat, 0);
            if (kind == 2) begin
               @(negedge clk);
               rst_n = 1'b1;
               repeat (3) @(negedge clk);
               check({tag, "_postrst_idle"}, {s_busy, s_done}, 0);
            end
            return;
         end
         @(negedge clk);
      end
      start_v[id] = 1'b0;
      corr[id] = '0;
      check({tag, "_latency"}, cyc, n + lat);
      check({tag, "_pass"}, s_pass, (mism == 0));
      check({tag, "_err"}, s_err, exp_err(mism));
      check({tag, "_busy_oe"}, bad_busy, 0);
      check({tag, "_drain_pat"}, bad_pat, 0);
      foreach (vq[i]) begin
         if (vq[i] == '0 || seen.exists(vq[i])) bad_vec++;
         seen[vq[i]] = 1'b1;
      end
      check({tag, "_distinct"}, bad_vec, 0);
      check({tag, "_nvec"}, vq.size(), n);
      if (vq.size() > 0) check({tag, "_first"}, vq[0], SD[id]);
      repeat (2) @(negedge clk);
      check({tag, "_hold"}, {s_done, s_pass, s_busy}, {1'b1, (mism == 0), 1'b0});
   endtask

   initial begin
      int unsigned diffs;
      for (int i = 0; i < 3; i++) corr[i] = '0;
      #1;
      check("rst_pat",  s_pat, 0);
      check("rst_oe",   s_oe, 0);
      check("rst_flags", {s_busy, s_done, s_pass}, 0);
      check("rst_err",  s_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_rst", {s_busy, s_done}, 0);

      run(0, 0, 0, NONE, NONE, "a_ideal");
      ref_q = vq;
      run(0, 1, 0, NONE, NONE, "a_stuck0");
      run(0, 0, 1, 50, NONE, "a_abort");
      run(0, 0, 0, NONE, 30, "a_poke");
      diffs = 0;
      foreach (vq[i]) if (i < ref_q.size() && vq[i] != ref_q[i]) diffs++;
      check("a_replay_size", vq.size(), ref_q.size());
      check("a_replay_diff", diffs, 0);
      run(0, 3, 0, NONE, NONE, "a_rand");

      run(1, 2, 0, NONE, NONE, "b_inv");
      run(1, 2, 2, NV[1], NONE, "b_rst");
      run(1, 3, 0, NONE, NONE, "b_rand");

      run(2, 0, 0, NONE, NONE, "c_lat0");
      for (int k = 0; k < 4; k++) run(2, 3, 0, NONE, NONE, "c_rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
